if_fetch_stage: RTL

Instruction fetch stage. It sits directly upstream of the decoder and produces the 32-bit instruction words that the decoder interprets through instruction_u. It owns the fetch PC and applies the nextPCType_e redirect selection (PC_PLUS4 / JUMP / TRAP). It talks to instruction memory over a req/gnt/rvalid interface and buffers up to DEPTH fetched instructions toward decode using a valid/ready handshake.

---
 rtl/if_fetch_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues one-at-a-time imem requests
// under a buffer-credit rule and queues {inst, pc} toward decode.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0004,
  parameter int unsigned DEPTH       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  next_pc_sel,
  input  logic [31:0] jump_addr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   opc_q, opc_d;
  logic          req_q, req_d;
  logic          out_q, out_d;
  logic          disc_q, disc_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic          redir, push, pop, credit;
  logic [31:0]   tgt;
  logic [AW+1:0] used;

  assign redir  = (next_pc_sel != 2'b00);
  assign tgt    = next_pc_sel[1] ? (TRAP_VECTOR & ~32'h3) : (jump_addr & ~32'h3);
  assign used   = (AW+2)'(cnt_q) + (AW+2)'(out_q);
  assign credit = (used < (AW+2)'(DEPTH));
  assign pop    = (cnt_q != '0) && id_ready;

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    addr_d  = addr_q;
    opc_d   = opc_q;
    req_d   = req_q;
    out_d   = out_q;
    disc_d  = disc_q;
    push    = 1'b0;

    if (redir) fpc_d = tgt;

    case (state_q)
      S_IDLE: begin
        // A redirect flushes the buffer, so credit is guaranteed; fetch the target at once.
        if (redir || credit) begin
          req_d   = 1'b1;
          addr_d  = redir ? tgt : fpc_q;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Address stays put until granted; a redirect only marks the response stale.
        if (redir) disc_d = 1'b1;
        if (imem_gnt) begin
          req_d   = 1'b0;
          out_d   = 1'b1;
          opc_d   = addr_q;
          state_d = S_RESP;
          if (!redir && !disc_q) fpc_d = fpc_q + 32'd4;
        end
      end
      S_RESP: begin
        if (redir) disc_d = 1'b1;
        if (imem_rvalid && out_q) begin
          push    = !redir && !disc_q;
          disc_d  = 1'b0;
          out_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (redir) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fpc_q   <= RESET_PC;
      addr_q  <= RESET_PC;
      opc_q   <= '0;
      req_q   <= 1'b0;
      out_q   <= 1'b0;
      disc_q  <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      addr_q  <= addr_d;
      opc_q   <= opc_d;
      req_q   <= req_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_q] <= imem_rdata;
      pc_mem[wr_q]   <= opc_q;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_valid  = (cnt_q != '0);
  assign id_inst   = id_valid ? inst_mem[rd_q] : NOP;
  assign id_pc     = id_valid ? pc_mem[rd_q]   : 32'h0;

endmodule
